spy_probe: RTL and testbench

- Parametrised on-board debug viewer, successor to the fixed 128-bit/4-LED viewer.
- Pushbuttons step a memory-address pointer and a slice selector over a probed vector; the selected slice drives LEDs.
- Adds input synchronisers, bounded address wrap, selector wrap, auto-repeat on held buttons, and a freeze button that captures a snapshot of the probed vector.
- Sits between board buttons/LEDs and any block exposing a debug vector and an address-indexed memory.

---
 rtl/spy_probe.sv | 216 +++++++++++++++++++++
 tb/tb_spy_probe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spy_probe.sv
// On-board debug viewer: debounced, auto-repeating pushbuttons step an address
// pointer and a slice selector over a probed vector; a freeze button snapshots it.
module spy_probe #(
    parameter int VEC_WIDTH       = 128,
    parameter int LED_WIDTH       = 4,
    parameter int ADDR_WIDTH      = 15,
    parameter int ADDR_MAX        = 2**ADDR_WIDTH - 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    localparam int NUM_SLICES     = VEC_WIDTH / LED_WIDTH,
    localparam int SEL_WIDTH      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            buttons,
    input  logic [VEC_WIDTH-1:0]  input_vector,
    output logic [LED_WIDTH-1:0]  output_led,
    output logic                  out_clk,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [SEL_WIDTH-1:0]  sel,
    output logic                  frozen
);

    localparam int NUM_BTN  = 5;
    localparam int CNT_MAX0 = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX  = (CNT_MAX0 > REPEAT_PERIOD) ? CNT_MAX0 : REPEAT_PERIOD;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0]      DEB_LOAD  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]      DLY_LOAD  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0]      PER_LOAD  = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = CNT_W'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP  = ADDR_WIDTH'(ADDR_MAX);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0]  SEL_TOP   = SEL_WIDTH'(NUM_SLICES - 1);
    localparam logic [SEL_WIDTH-1:0]  SEL_ZERO  = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0]  SEL_ONE   = SEL_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_LOCK = 2'd1,
        ST_HELD       = 2'd2,
        ST_REL_LOCK   = 2'd3
    } btn_state_e;

    logic [NUM_BTN-1:0]    sync1_q, sync1_d;
    logic [NUM_BTN-1:0]    sync2_q, sync2_d;
    btn_state_e            state_q [NUM_BTN];
    btn_state_e            state_d [NUM_BTN];
    logic [CNT_W-1:0]      cnt_q   [NUM_BTN];
    logic [CNT_W-1:0]      cnt_d   [NUM_BTN];
    logic [NUM_BTN-1:0]    pulse_q, pulse_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  frozen_q, frozen_d;
    logic [VEC_WIDTH-1:0]  snap_q, snap_d;
    logic [LED_WIDTH-1:0]  led_q, led_d;
    logic [VEC_WIDTH-1:0]  view_s;

    logic addr_up_s, addr_dn_s, sel_dn_s, sel_up_s, freeze_s;

    // Two-stage synchroniser for the raw board buttons.
    always_comb begin
        sync1_d = buttons;
        sync2_d = sync1_q;
    end

    // Per-button press/lockout/repeat FSM; one shared counter serves lockout and repeat.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            pulse_d[i] = 1'b0;
            case (state_q[i])
                ST_IDLE: begin
                    if (sync2_q[i]) begin
                        pulse_d[i] = 1'b1;
                        cnt_d[i]   = DEB_LOAD;
                        state_d[i] = ST_PRESS_LOCK;
                    end else begin
                        cnt_d[i]   = CNT_ZERO;
                    end
                end
                ST_PRESS_LOCK: begin
                    if (cnt_q[i] == CNT_ZERO) begin
                        cnt_d[i]   = DLY_LOAD;
                        state_d[i] = ST_HELD;
                    end else begin
                        cnt_d[i]   = cnt_q[i] - CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!sync2_q[i]) begin
                        cnt_d[i]   = DEB_LOAD;
                        state_d[i] = ST_REL_LOCK;
                    end else if (REPEAT_DELAY != 0) begin
                        // Fire on the cycle the count would reach zero, then reload.
                        if (cnt_q[i] <= CNT_ONE) begin
                            pulse_d[i] = 1'b1;
                            cnt_d[i]   = PER_LOAD;
                        end else begin
                            cnt_d[i]   = cnt_q[i] - CNT_ONE;
                        end
                    end else begin
                        cnt_d[i]   = cnt_q[i];
                    end
                end
                ST_REL_LOCK: begin
                    if (cnt_q[i] == CNT_ZERO) begin
                        state_d[i] = ST_IDLE;
                    end else begin
                        cnt_d[i]   = cnt_q[i] - CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = CNT_ZERO;
                end
            endcase
        end
    end

    assign addr_up_s = pulse_q[0];
    assign addr_dn_s = pulse_q[1];
    assign sel_dn_s  = pulse_q[2];
    assign sel_up_s  = pulse_q[3];
    assign freeze_s  = pulse_q[4];

    // Address pointer with bounded wrap in both directions.
    always_comb begin
        addr_d = addr_q;
        if (addr_up_s && !addr_dn_s) begin
            addr_d = (addr_q >= ADDR_TOP) ? ADDR_ZERO : addr_q + ADDR_ONE;
        end else if (addr_dn_s && !addr_up_s) begin
            addr_d = (addr_q == ADDR_ZERO || addr_q > ADDR_TOP) ? ADDR_TOP : addr_q - ADDR_ONE;
        end else begin
            addr_d = addr_q;
        end
    end

    // Slice selector; wraps so it never leaves the range of valid slices.
    always_comb begin
        sel_d = sel_q;
        if (sel_up_s && !sel_dn_s) begin
            sel_d = (sel_q >= SEL_TOP) ? SEL_ZERO : sel_q + SEL_ONE;
        end else if (sel_dn_s && !sel_up_s) begin
            sel_d = (sel_q == SEL_ZERO || sel_q > SEL_TOP) ? SEL_TOP : sel_q - SEL_ONE;
        end else begin
            sel_d = sel_q;
        end
    end

    // Freeze toggle; the snapshot is taken only when entering the frozen state.
    always_comb begin
        frozen_d = frozen_q;
        snap_d   = snap_q;
        if (freeze_s) begin
            frozen_d = ~frozen_q;
            if (!frozen_q) begin
                snap_d = input_vector;
            end else begin
                snap_d = snap_q;
            end
        end else begin
            frozen_d = frozen_q;
        end
    end

    // Display path: slice of either the live vector or the snapshot.
    always_comb begin
        view_s = frozen_q ? snap_q : input_vector;
        led_d  = view_s[LED_WIDTH*int'(sel_q) +: LED_WIDTH];
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            pulse_q  <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= CNT_ZERO;
            end
            addr_q   <= ADDR_ZERO;
            sel_q    <= SEL_ZERO;
            frozen_q <= 1'b0;
            snap_q   <= '0;
            led_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            pulse_q  <= pulse_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            frozen_q <= frozen_d;
            snap_q   <= snap_d;
            led_q    <= led_d;
        end
    end

    assign output_led  = led_q;
    assign mem_address = addr_q;
    assign sel         = sel_q;
    assign frozen      = frozen_q;
    assign out_clk     = clk;

endmodule

// File: tb/tb_spy_probe.sv
// Directed self-checking bench for spy_probe with short debounce/repeat timing.
module tb_spy_probe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  buttons = 5'd0;
    logic [15:0] input_vector = 16'h0000;
    logic [3:0]  output_led;
    logic        out_clk;
    logic [3:0]  mem_address;
    logic [1:0]  sel;
    logic        frozen;

    int checks = 0;
    int failures = 0;

    spy_probe #(
        .VEC_WIDTH(16), .LED_WIDTH(4), .ADDR_WIDTH(4), .ADDR_MAX(9),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk), .reset(reset), .buttons(buttons), .input_vector(input_vector),
        .output_led(output_led), .out_clk(out_clk), .mem_address(mem_address),
        .sel(sel), .frozen(frozen)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        buttons = 5'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Press for one cycle (edge k) and return just after edge k+3.
    task automatic tap(input logic [4:0] mask);
        buttons = mask;
        tick();
        buttons = 5'd0;
        settle(3);
    endtask

    logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] led_old [4] = '{4'h3, 4'hC, 4'h5, 4'hA};
    logic [3:0] led_new [4] = '{4'hC, 4'h5, 4'hA, 4'h3};

    initial begin
        // Reset state
        tick();
        do_reset();
        check_eq("rst_addr", 32'(mem_address), 32'd0);
        check_eq("rst_sel", 32'(sel), 32'd0);
        check_eq("rst_led", 32'(output_led), 32'd0);
        check_eq("rst_frozen", 32'(frozen), 32'd0);
        check_eq("out_clk", 32'(out_clk), 32'd1);

        // 1: single step with bounce inside the lockout
        buttons = 5'b00001; tick();
        buttons = 5'b00000; tick();
        buttons = 5'b00001; tick();
        check_eq("t1_addr_k2", 32'(mem_address), 32'd0);
        buttons = 5'b00000; tick();
        check_eq("t1_addr_k3", 32'(mem_address), 32'd1);
        buttons = 5'b00001; tick();
        buttons = 5'b00000;
        settle(20);
        check_eq("t1_bounce", 32'(mem_address), 32'd1);

        // 2: address wrap both ways, simultaneous up/down
        do_reset();
        tap(5'b00010);
        check_eq("t2_down_wrap", 32'(mem_address), 32'd9);
        settle(15);
        tap(5'b00001);
        check_eq("t2_up_wrap", 32'(mem_address), 32'd0);
        settle(15);
        tap(5'b00001);
        check_eq("t2_up", 32'(mem_address), 32'd1);
        settle(15);
        tap(5'b00011);
        check_eq("t2_both", 32'(mem_address), 32'd1);
        settle(15);

        // 3: selector stepping and slice display
        do_reset();
        input_vector = 16'hA5C3;
        settle(2);
        for (int i = 0; i < 4; i++) begin
            tap(5'b01000);
            check_eq($sformatf("t3_sel%0d", i), 32'(sel), 32'(exp_sel[i]));
            check_eq($sformatf("t3_led_old%0d", i), 32'(output_led), 32'(led_old[i]));
            tick();
            check_eq($sformatf("t3_led_new%0d", i), 32'(output_led), 32'(led_new[i]));
            settle(15);
        end
        tap(5'b00100);
        check_eq("t3_sel_dn_wrap", 32'(sel), 32'd3);
        tick();
        check_eq("t3_led_dn", 32'(output_led), 32'hA);
        settle(15);

        // 5: freeze snapshot (sel back to 0 first)
        tap(5'b01000);
        check_eq("t5_sel0", 32'(sel), 32'd0);
        settle(15);
        input_vector = 16'h1234;
        settle(2);
        tap(5'b10000);
        check_eq("t5_frozen1", 32'(frozen), 32'd1);
        tick();
        input_vector = 16'hFFFF;
        settle(3);
        check_eq("t5_led_held", 32'(output_led), 32'h4);
        settle(15);
        tap(5'b10000);
        check_eq("t5_frozen0", 32'(frozen), 32'd0);
        check_eq("t5_led_lag", 32'(output_led), 32'h4);
        tick();
        check_eq("t5_led_live", 32'(output_led), 32'hF);
        settle(15);

        // 4: held button auto-repeat from 0 (press + 7 repeats in 60 cycles)
        do_reset();
        buttons = 5'b00001;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 3)  check_eq("t4_pre", 32'(mem_address), 32'd0);
            if (i == 4)  check_eq("t4_press", 32'(mem_address), 32'd1);
            if (i == 28) check_eq("t4_no_early_rep", 32'(mem_address), 32'd1);
            if (i == 29) check_eq("t4_first_rep", 32'(mem_address), 32'd2);
            if (i == 34) check_eq("t4_second_rep", 32'(mem_address), 32'd3);
        end
        buttons = 5'b00000;
        settle(20);
        check_eq("t4_final", 32'(mem_address), 32'd8);

        // 4b: held from 8, press + 3 repeats wraps 8->9->0->1->2
        do_reset();
        tap(5'b00010); settle(15);
        tap(5'b00010); settle(15);
        check_eq("t4b_start", 32'(mem_address), 32'd8);
        buttons = 5'b00001;
        settle(40);
        buttons = 5'b00000;
        settle(20);
        check_eq("t4b_wrap", 32'(mem_address), 32'd2);

        // 6: reset while a button is held in HELD
        do_reset();
        input_vector = 16'h1234;
        buttons = 5'b01000;
        settle(12);
        check_eq("t6_pre_sel", 32'(sel), 32'd1);
        reset = 1'b1;
        tick();
        check_eq("t6_rst_sel", 32'(sel), 32'd0);
        check_eq("t6_rst_addr", 32'(mem_address), 32'd0);
        check_eq("t6_rst_led", 32'(output_led), 32'd0);
        check_eq("t6_rst_frozen", 32'(frozen), 32'd0);
        reset = 1'b0;
        // button is sampled at edge r+1, visible at r+3, sel steps at r+4
        for (int j = 1; j <= 29; j++) begin
            tick();
            if (j == 3)  check_eq("t6_sel_r3", 32'(sel), 32'd0);
            if (j == 4)  check_eq("t6_sel_r4", 32'(sel), 32'd1);
            if (j == 28) check_eq("t6_no_rep", 32'(sel), 32'd1);
            if (j == 29) check_eq("t6_rep", 32'(sel), 32'd2);
        end
        buttons = 5'b00000;
        settle(20);
        check_eq("t6_final", 32'(sel), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
